ifu_fetch_buf: RTL and testbench

- Instruction-fetch front end that feeds the first decode stage.
- Generates sequential fetch addresses to instruction memory and buffers in-order responses in a small FIFO.
- Presents one instruction per cycle as instr/instr_valid/instr_tag (tag = instruction PC).
- Honours pipe_stall (hold) and pipe_flush (redirect to flush_pc, discard in-flight and buffered instructions).

---
 rtl/ifu_fetch_buf.sv | 117 +++++++++++
 tb/tb_ifu_fetch_buf.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_buf.sv
// ============================================================================
//  ifu_fetch_buf : sequential instruction fetch with credit-limited response
//  FIFO and a stallable/flushable output register feeding decode.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module ifu_fetch_buf #(
  parameter int              XLEN       = 32,
  parameter int              INSTR_LEN  = 32,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [XLEN-1:0]      imem_req_addr,
  input  logic                 imem_rsp_valid,
  input  logic [INSTR_LEN-1:0] imem_rsp_data,
  input  logic                 pipe_stall,
  input  logic                 pipe_flush,
  input  logic [XLEN-1:0]      flush_pc,
  output logic [INSTR_LEN-1:0] instr,
  output logic                 instr_valid,
  output logic [XLEN-1:0]      instr_tag
);

  localparam int              AW      = $clog2(FIFO_DEPTH);
  localparam int              CW      = AW + 1;
  localparam logic [CW:0]     DEPTH_W = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]   ONE     = CW'(1);
  localparam logic [AW-1:0]   PTR_ONE = AW'(1);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0]      fetch_pc;
  logic [XLEN-1:0]      out_pc;
  logic [CW-1:0]        outstanding;
  logic [CW-1:0]        drop_cnt;
  logic [CW-1:0]        fifo_count;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [INSTR_LEN-1:0] fifo_mem [FIFO_DEPTH];

  logic [CW:0] in_use;
  logic        req_fire;
  logic        rsp_keep;
  logic        pop;

  // Every issued request owns a FIFO slot until it is consumed, so the
  // buffer can never overflow even though responses are never back-pressured.
  assign in_use         = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_valid = rst_n & ~pipe_flush & (in_use < DEPTH_W);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign rsp_keep       = imem_rsp_valid & ~pipe_flush & (drop_cnt == '0);
  assign pop            = ~pipe_flush & ~pipe_stall & (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      out_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      instr       <= '0;
      instr_tag   <= '0;
      instr_valid <= 1'b0;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
      outstanding <= outstanding + (req_fire ? ONE : '0) - (imem_rsp_valid ? ONE : '0);

      if (pipe_flush) begin
        // Anything still in flight after this edge belongs to the old path.
        fetch_pc    <= flush_pc;
        out_pc      <= flush_pc;
        drop_cnt    <= outstanding - (imem_rsp_valid ? ONE : '0);
        fifo_count  <= '0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        instr_valid <= 1'b0;
      end else begin
        if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - ONE;
        if (rsp_keep) wr_ptr <= wr_ptr + PTR_ONE;
        fifo_count <= fifo_count + (rsp_keep ? ONE : '0) - (pop ? ONE : '0);
        if (!pipe_stall) begin
          instr_valid <= pop;
          if (pop) begin
            instr     <= fifo_mem[rd_ptr];
            instr_tag <= out_pc;
            out_pc    <= out_pc + PC_STEP;
            rd_ptr    <= rd_ptr + PTR_ONE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rsp_keep) fifo_mem[wr_ptr] <= imem_rsp_data;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(rsp_keep && (fifo_count == DEPTH_C)));
      assert (outstanding <= DEPTH_C);
      assert (drop_cnt <= DEPTH_C);
      assert (fifo_count <= DEPTH_C);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch_buf.sv
// Scoreboard bench for ifu_fetch_buf: in-order memory model, expected
// deliveries queued at request acceptance and cleared on flush/reset.
`timescale 1ns/1ps
`default_nettype none

module tb_ifu_fetch_buf;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        pipe_stall, pipe_flush;
  logic [31:0] flush_pc;
  logic [31:0] instr, instr_tag;
  logic        instr_valid;

  ifu_fetch_buf #(.XLEN(32), .INSTR_LEN(32), .FIFO_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .pipe_stall(pipe_stall), .pipe_flush(pipe_flush), .flush_pc(flush_pc),
    .instr(instr), .instr_valid(instr_valid), .instr_tag(instr_tag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; logic [31:0] addr; } req_t;
  typedef struct { logic [31:0] tag; logic [31:0] data; } exp_t;

  req_t        pend[$];
  exp_t        exp_q[$];
  logic [31:0] model_pc = RPC;
  int          n_cmp = 0, n_fail = 0;
  int          first_rsp_cyc = -1, first_valid_cyc = -1;
  bit          stream_mode = 1'b0, gap_seen = 1'b0;
  bit          last_req_valid = 1'b0;
  bit          dmy;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // One clock of stimulus. flm: 0 no flush, 1 flush, 2 flush only if a response is returned.
  task automatic step(input bit rdy, input bit stl, input int flm, input logic [31:0] fpc,
                      input int lat, output bit did_fl);
    bit fl;
    @(negedge clk);
    rst_n = 1'b1;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_data(pend[0].addr);
      void'(pend.pop_front());
      if (first_rsp_cyc < 0) first_rsp_cyc = cyc;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    fl = (flm == 1) || (flm == 2 && imem_rsp_valid);
    imem_req_ready = rdy;
    pipe_stall     = stl;
    pipe_flush     = fl;
    flush_pc       = fl ? fpc : $urandom;
    #1;
    last_req_valid = imem_req_valid;
    if (fl) chk("flush_no_req", {63'd0, imem_req_valid}, 64'd0);
    else if (imem_req_valid) chk("req_addr", {32'd0, imem_req_addr}, {32'd0, model_pc});
    if (imem_req_valid && rdy) begin
      pend.push_back('{due: cyc + lat, addr: imem_req_addr});
      exp_q.push_back('{tag: model_pc, data: mem_data(model_pc)});
      model_pc = model_pc + 32'd4;
      chk("inflight_limit", {63'd0, pend.size() <= DEPTH}, 64'd1);
    end
    if (fl) begin
      exp_q.delete();
      model_pc = fpc;
    end
    did_fl = fl;
  endtask

  task automatic run(input int n, input bit rdy, input bit stl, input int lat);
    for (int i = 0; i < n; i++) step(rdy, stl, 0, 32'd0, lat, dmy);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0; imem_rsp_valid = 1'b0; imem_req_ready = 1'b1;
    pipe_stall = 1'b0; pipe_flush = 1'b0;
    pend.delete(); exp_q.delete();
    model_pc = RPC; first_rsp_cyc = -1; first_valid_cyc = -1;
    #1 chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    repeat (n - 1) @(negedge clk);
  endtask

  // Monitor: samples just after each active edge.
  initial begin
    logic        hold_v;
    logic [31:0] hold_i, hold_t;
    exp_t        e;
    hold_v = 1'b0; hold_i = '0; hold_t = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        chk("rst_instr_valid", {63'd0, instr_valid}, 64'd0);
        chk("rst_instr", {32'd0, instr}, 64'd0);
        chk("rst_instr_tag", {32'd0, instr_tag}, 64'd0);
      end else if (pipe_flush) begin
        chk("flush_invalid", {63'd0, instr_valid}, 64'd0);
      end else if (pipe_stall) begin
        chk("stall_hold", {instr_valid, instr_tag, instr}, {hold_v, hold_t, hold_i});
      end else if (instr_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_instr_tag", {32'd0, instr_tag}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("instr_tag", {32'd0, instr_tag}, {32'd0, e.tag});
          chk("instr_data", {32'd0, instr}, {32'd0, e.data});
        end
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end else if (stream_mode && first_valid_cyc >= 0) begin
        gap_seen = 1'b1;
      end
      hold_v = instr_valid; hold_i = instr; hold_t = instr_tag;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    pipe_stall = 1'b0; pipe_flush = 1'b0; flush_pc = '0;

    // Streaming with a 1-cycle memory
    do_reset(2);
    stream_mode = 1'b1;
    run(30, 1'b1, 1'b0, 1);
    stream_mode = 1'b0;
    chk("first_latency", 64'(first_valid_cyc - first_rsp_cyc), 64'd2);
    chk("stream_gap", {63'd0, gap_seen}, 64'd0);

    // Long stall: credits run out, output frozen
    run(10, 1'b1, 1'b1, 1);
    chk("stall_credit_stop", {63'd0, last_req_valid}, 64'd0);
    run(20, 1'b1, 1'b0, 1);

    // Back-pressure: request held, address stable
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 0, 32'd0, 1, dmy);
      chk("bp_req_held", {63'd0, last_req_valid}, 64'd1);
    end
    run(10, 1'b1, 1'b0, 1);

    // Flush with requests in flight and instructions buffered
    run(3, 1'b1, 1'b1, 3);
    step(1'b1, 1'b1, 1, 32'h0000_0100, 3, dmy);
    run(20, 1'b1, 1'b0, 1);

    // Flush near the top of the address space: PC wraps
    step(1'b1, 1'b0, 1, 32'hFFFF_FFF8, 2, dmy);
    run(12, 1'b1, 1'b0, 2);

    // Back-to-back flushes with slow memory
    run(5, 1'b1, 1'b0, 3);
    step(1'b1, 1'b0, 1, 32'h0000_0300, 3, dmy);
    step(1'b1, 1'b0, 1, 32'h0000_0400, 3, dmy);
    run(15, 1'b1, 1'b0, 1);

    // Flush coincident with a response while stalled
    run(5, 1'b1, 1'b0, 1);
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 10 && !hit; i++) step(1'b1, 1'b1, 2, 32'h0000_0500, 1, hit);
      chk("flush_with_rsp", {63'd0, hit}, 64'd1);
    end
    run(15, 1'b1, 1'b0, 1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
           ($urandom_range(0, 19) == 0) ? 1 : 0, $urandom & 32'hFFFF_FFFC,
           $urandom_range(1, 3), dmy);

    // Reset mid-operation with a non-empty FIFO
    run(5, 1'b1, 1'b0, 1);
    run(3, 1'b1, 1'b1, 1);
    do_reset(1);
    run(10, 1'b1, 1'b0, 1);

    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
           ($urandom_range(0, 19) == 0) ? 1 : 0, $urandom & 32'hFFFF_FFFC,
           $urandom_range(1, 3), dmy);

    // Drain: every accepted request must have been delivered
    run(30, 1'b0, 1'b0, 1);
    chk("drain_exp_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_mem_empty", 64'(pend.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
